// File: rtl/unpooling_pkg.sv
// Shared helpers for the 2x2 nearest-neighbour unpooling stage.
//   log2          : ceil(log2(value)); sizes counters and buffer indices
//   pixel_bits    : packed pixel width (channel width x channel count)
//   coarse_index  : line-buffer column index of a full-resolution counter
//   bank_select   : ping-pong bank owning a full-resolution line counter
//   is_coarse     : counter sits on the last fine position of a coarse cell
package unpooling_pkg;

  localparam int unsigned BANKS = 2;

  function automatic int unsigned log2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  function automatic int unsigned pixel_bits(input int unsigned fixed_bitw,
                                             input int unsigned units);
    return fixed_bitw * units;
  endfunction

  function automatic logic [31:0] coarse_index(input logic [31:0] cnt,
                                               input int unsigned level);
    return cnt >> (level + 1);
  endfunction

  function automatic logic bank_select(input logic [31:0] cnt,
                                       input int unsigned level);
    return cnt[level+1];
  endfunction

  function automatic logic is_coarse(input logic [31:0] cnt,
                                     input int unsigned level);
    logic [31:0] mask;
    mask = (32'd1 << (level + 1)) - 32'd1;
    return (cnt & mask) == mask;
  endfunction

endpackage

// File: rtl/delay.sv
// Fixed-latency register pipeline with asynchronous active-low clear.
//   clock   : rising-edge clock
//   n_rst   : asynchronous active-low reset, clears every stage to zero
//   value   : BITW-bit input sampled every cycle
//   delayed : value from LATENCY cycles earlier (LATENCY >= 1)
module delay #(
  parameter int unsigned BITW    = 1,
  parameter int unsigned LATENCY = 1
) (
  input  logic            clock,
  input  logic            n_rst,
  input  logic [BITW-1:0] value,
  output logic [BITW-1:0] delayed
);

  logic [BITW-1:0] pipe [LATENCY];

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= value;
      for (int unsigned i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign delayed = pipe[LATENCY-1];

endmodule

// File: rtl/unpool_line_buffer.sv
// Two-bank ping-pong line buffer for one coarse row per bank.
// Simple dual port: one write and one registered read per cycle. Each bank
// carries a valid bit, set when its first entry (index 0) is written, so a
// bank that has not been refilled since reset reads back as zero.
//   clock, n_rst : clock and asynchronous active-low reset (valid bits and
//                  read register only; storage is not cleared)
//   write_en/write_bank/write_addr/write_data : write port
//   read_bank/read_addr : read address, data appears next cycle
//   read_data    : registered read data, zero for an invalid bank
module unpool_line_buffer
  import unpooling_pkg::*;
#(
  parameter int unsigned DATA_BITW = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_BITW = 2
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 write_en,
  input  logic                 write_bank,
  input  logic [ADDR_BITW-1:0] write_addr,
  input  logic [DATA_BITW-1:0] write_data,
  input  logic                 read_bank,
  input  logic [ADDR_BITW-1:0] read_addr,
  output logic [DATA_BITW-1:0] read_data
);

  logic [DATA_BITW-1:0] mem [BANKS][DEPTH];
  logic [BANKS-1:0]     bank_valid;

  always_ff @(posedge clock) begin
    if (write_en) mem[write_bank][write_addr] <= write_data;
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      bank_valid <= '0;
    end else if (write_en && (write_addr == '0)) begin
      bank_valid[write_bank] <= 1'b1;
    end
  end

  // The read bank is always the one not being written, so no bypass is needed.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      read_data <= '0;
    end else begin
      read_data <= bank_valid[read_bank] ? mem[read_bank][read_addr] : '0;
    end
  end

endmodule

// File: rtl/unpooling.sv
// 2x2 nearest-neighbour upsampling stage (inverse of 2x2 max pooling).
// Coarse samples at level LEVEL+1 are stored row by row in a ping-pong line
// buffer and replayed as 2x2 blocks at level LEVEL. The output frame trails
// the input frame by 2^(LEVEL+1) lines plus a 2-cycle pipeline.
//   clock      : rising-edge clock
//   n_rst      : asynchronous active-low reset
//   in_enable  : in_pixels valid
//   in_pixels  : UNITS channels of FIXED_BITW bits, channel p at [p*FIXED_BITW +: FIXED_BITW]
//   in_vcnt    : full-frame line counter
//   in_hcnt    : full-frame column counter
//   out_enable : output pixel valid at level LEVEL
//   out_pixels : replicated pixel, same packing as in_pixels
//   out_vcnt   : output line counter
//   out_hcnt   : output column counter
module unpooling
  import unpooling_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned HEIGHT     = 8,
  parameter int unsigned W_WIDTH    = 8,
  parameter int unsigned W_HEIGHT   = 8,
  parameter int unsigned FIXED_BITW = 8,
  parameter int unsigned UNITS      = 2,
  parameter int unsigned LEVEL      = 0,
  parameter int unsigned V_BITW     = log2(W_HEIGHT),
  parameter int unsigned H_BITW     = log2(W_WIDTH)
) (
  input  logic                        clock,
  input  logic                        n_rst,
  input  logic                        in_enable,
  input  logic [FIXED_BITW*UNITS-1:0] in_pixels,
  input  logic [V_BITW-1:0]           in_vcnt,
  input  logic [H_BITW-1:0]           in_hcnt,
  output logic                        out_enable,
  output logic [FIXED_BITW*UNITS-1:0] out_pixels,
  output logic [V_BITW-1:0]           out_vcnt,
  output logic [H_BITW-1:0]           out_hcnt
);

  localparam int unsigned PIX_BITW = pixel_bits(FIXED_BITW, UNITS);
  localparam int unsigned DEPTH    = W_WIDTH >> (LEVEL + 1);
  localparam int unsigned IDX_BITW = (log2(DEPTH) > 0) ? log2(DEPTH) : 1;
  localparam logic [V_BITW-1:0] V_LAG = V_BITW'(1 << (LEVEL + 1));

  // Stage 0: write/read addressing and output coordinates.
  logic                coarse_sample;
  logic                write_bank;
  logic [IDX_BITW-1:0] write_idx;
  logic                read_bank;
  logic [IDX_BITW-1:0] read_idx;
  logic [V_BITW-1:0]   ov;
  logic [H_BITW-1:0]   oh;
  logic                in_range;

  always_comb begin
    coarse_sample = in_enable
                    && is_coarse(32'(in_hcnt), LEVEL)
                    && is_coarse(32'(in_vcnt), LEVEL);
    write_idx     = IDX_BITW'(coarse_index(32'(in_hcnt), LEVEL));
    write_bank    = bank_select(32'(in_vcnt), LEVEL);
    // Wraps modulo W_HEIGHT, so the first lines of a frame replay the
    // bottom coarse rows of the previous frame.
    ov            = in_vcnt - V_LAG;
    oh            = in_hcnt;
    read_idx      = IDX_BITW'(coarse_index(32'(oh), LEVEL));
    read_bank     = bank_select(32'(ov), LEVEL);
    in_range      = (32'(ov) < HEIGHT) && (32'(oh) < WIDTH);
  end

  // Stage 1: registered read data (inside the buffer) and range flag.
  logic [PIX_BITW-1:0] read_data;
  logic                in_range_s1;

  unpool_line_buffer #(
    .DATA_BITW (PIX_BITW),
    .DEPTH     (DEPTH),
    .ADDR_BITW (IDX_BITW)
  ) line_buffer (
    .clock      (clock),
    .n_rst      (n_rst),
    .write_en   (coarse_sample),
    .write_bank (write_bank),
    .write_addr (write_idx),
    .write_data (in_pixels),
    .read_bank  (read_bank),
    .read_addr  (read_idx),
    .read_data  (read_data)
  );

  // Stage 2: masked output register.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      in_range_s1 <= 1'b0;
      out_pixels  <= '0;
    end else begin
      in_range_s1 <= in_range;
      out_pixels  <= in_range_s1 ? read_data : '0;
    end
  end

  logic [V_BITW+H_BITW-1:0] coord_out;

  delay #(
    .BITW    (V_BITW + H_BITW),
    .LATENCY (2)
  ) coord_delay (
    .clock   (clock),
    .n_rst   (n_rst),
    .value   ({ov, oh}),
    .delayed (coord_out)
  );

  assign {out_vcnt, out_hcnt} = coord_out;

  generate
    if (LEVEL == 0) begin : g_full_rate
      assign out_enable = 1'b1;
    end else begin : g_sub_rate
      assign out_enable = (&out_hcnt[LEVEL-1:0]) && (&out_vcnt[LEVEL-1:0]);
    end
  endgenerate

endmodule

// File: tb/tb_unpooling.sv
module tb_unpooling;

  logic        clock = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_enable = 1'b0;
  logic [15:0] in_pixels = '0;
  logic [2:0]  in_vcnt = '0;
  logic [2:0]  in_hcnt = '0;
  logic        out_enable;
  logic [15:0] out_pixels;
  logic [2:0]  out_vcnt;
  logic [2:0]  out_hcnt;

  always #5 clock = ~clock;

  unpooling #(
    .WIDTH      (8),
    .HEIGHT     (8),
    .W_WIDTH    (8),
    .W_HEIGHT   (8),
    .FIXED_BITW (8),
    .UNITS      (2),
    .LEVEL      (0)
  ) dut (
    .clock      (clock),
    .n_rst      (n_rst),
    .in_enable  (in_enable),
    .in_pixels  (in_pixels),
    .in_vcnt    (in_vcnt),
    .in_hcnt    (in_hcnt),
    .out_enable (out_enable),
    .out_pixels (out_pixels),
    .out_vcnt   (out_vcnt),
    .out_hcnt   (out_hcnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Coarse image for the frame being driven, and per-sample enables.
  logic [15:0] stim [4][4];
  logic        stim_en [4][4];
  // Output pixels captured by source-frame parity, line, column.
  logic [15:0] capt [2][8][8];

  // Two-deep history of driven coordinates (output lags by 2 cycles).
  int   hv [2];
  int   hh [2];
  int   hf [2];
  logic hok [2];

  logic [15:0] obs_pix;
  int          obs_v, obs_h;
  logic        obs_en, obs_ok;
  int          exp_v, exp_h, exp_f;

  function automatic logic [15:0] ramp_pix(input int r, input int c);
    logic [7:0] a;
    a = 8'(r * 16 + c);
    return {a, ~a};
  endfunction

  function automatic logic coarse_pos(input int v, input int h);
    return (v % 2 == 1) && (h % 2 == 1);
  endfunction

  function automatic logic drive_en(input int v, input int h);
    return coarse_pos(v, h) ? stim_en[v/2][h/2] : 1'b1;
  endfunction

  // Non-coarse positions carry enabled garbage that must never be stored.
  function automatic logic [15:0] drive_pix(input int v, input int h);
    if (!coarse_pos(v, h)) return 16'hDEAD;
    return stim_en[v/2][h/2] ? stim[v/2][h/2] : 16'h9999;
  endfunction

  task automatic fill_stim(input logic [15:0] value);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        stim[r][c]    = value;
        stim_en[r][c] = 1'b1;
      end
  endtask

  // One clock: sample outputs at the negedge, then drive the next input.
  task automatic cycle(input int v, input int h, input int f,
                       input logic en, input logic [15:0] pix);
    @(negedge clock);
    obs_pix = out_pixels;
    obs_v   = int'(out_vcnt);
    obs_h   = int'(out_hcnt);
    obs_en  = out_enable;
    obs_ok  = hok[1];
    exp_v   = (hv[1] + 6) % 8;
    exp_h   = hh[1];
    exp_f   = (hv[1] >= 2) ? hf[1] : hf[1] - 1;
    if (obs_ok) capt[exp_f & 1][exp_v][exp_h] = obs_pix;
    hv[1] = hv[0]; hh[1] = hh[0]; hf[1] = hf[0]; hok[1] = hok[0];
    hv[0] = v;     hh[0] = h;     hf[0] = f;     hok[0] = 1'b1;
    in_vcnt   = 3'(v);
    in_hcnt   = 3'(h);
    in_enable = en;
    in_pixels = pix;
  endtask

  task automatic run_span(input int f, input int v0, input int h0,
                          input int v1, input int h1);
    for (int idx = v0 * 8 + h0; idx <= v1 * 8 + h1; idx++) begin
      if (idx == 0) begin
        for (int y = 0; y < 8; y++)
          for (int x = 0; x < 8; x++) capt[f & 1][y][x] = 'x;
      end
      cycle(idx / 8, idx % 8, f, drive_en(idx / 8, idx % 8),
            drive_pix(idx / 8, idx % 8));
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    hok[0] = 1'b0;
    hok[1] = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (out_pixels !== 16'h0000) begin
      miscompares++; $display("FAIL reset_pixels got %h expected 0000", out_pixels);
    end
    vectors++;
    if (out_vcnt !== 3'd0) begin
      miscompares++; $display("FAIL reset_vcnt got %0d expected 0", out_vcnt);
    end
    vectors++;
    if (out_hcnt !== 3'd0) begin
      miscompares++; $display("FAIL reset_hcnt got %0d expected 0", out_hcnt);
    end
    vectors++;
    if (out_enable !== 1'b1) begin
      miscompares++; $display("FAIL reset_enable got %b expected 1", out_enable);
    end
  endtask

  // Frame 0 straight out of reset: pipeline fill, counters, invalid bank.
  task automatic test_fill_after_reset();
    fill_stim(16'h0000);
    stim[0][0] = 16'h1122;
    stim[1][2] = 16'h80FF;
    for (int idx = 0; idx < 64; idx++) begin
      cycle(idx / 8, idx % 8, 0, drive_en(idx / 8, idx % 8),
            drive_pix(idx / 8, idx % 8));
      if (idx == 0) n_rst = 1'b1;
      if (idx <= 1) begin
        vectors++;
        if (obs_v !== 0 || obs_h !== 0 || obs_pix !== 16'h0000) begin
          miscompares++;
          $display("FAIL fill_idle got v=%0d h=%0d pix=%h expected 0 0 0000",
                   obs_v, obs_h, obs_pix);
        end
      end else begin
        vectors++;
        if (obs_v !== exp_v || obs_h !== exp_h) begin
          miscompares++;
          $display("FAIL fill_coords got v=%0d h=%0d expected v=%0d h=%0d",
                   obs_v, obs_h, exp_v, exp_h);
        end
        vectors++;
        if (obs_en !== 1'b1) begin
          miscompares++; $display("FAIL fill_enable got %b expected 1", obs_en);
        end
      end
      if (idx == 2) begin
        vectors++;
        if (obs_v !== 6 || obs_h !== 0) begin
          miscompares++;
          $display("FAIL first_line got v=%0d h=%0d expected v=6 h=0", obs_v, obs_h);
        end
      end
      if (idx >= 2 && idx <= 17) begin
        vectors++;
        if (obs_pix !== 16'h0000) begin
          miscompares++;
          $display("FAIL invalid_bank got %h expected 0000 at idx %0d", obs_pix, idx);
        end
      end
      if (idx == 18) begin
        vectors++;
        if (obs_v !== 0 || obs_h !== 0 || obs_pix !== 16'h1122) begin
          miscompares++;
          $display("FAIL first_block got v=%0d h=%0d pix=%h expected 0 0 1122",
                   obs_v, obs_h, obs_pix);
        end
      end
    end
  endtask

  // Frame 1 (ramp) is driven; this flushes and checks frame 0's blocks.
  task automatic test_single_blocks();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        stim[r][c]    = ramp_pix(r, c);
        stim_en[r][c] = 1'b1;
      end
    run_span(1, 0, 0, 7, 7);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        logic [15:0] want;
        want = 16'h0000;
        if (y < 2 && x < 2) want = 16'h1122;
        if (y >= 2 && y < 4 && x >= 4 && x < 6) want = 16'h80FF;
        vectors++;
        if (capt[0][y][x] !== want) begin
          miscompares++;
          $display("FAIL block (%0d,%0d) got %h expected %h", y, x, capt[0][y][x], want);
        end
      end
  endtask

  // Frame 2 is driven; frame 1's ramp (including rows 6..7) is checked.
  task automatic test_ramp();
    fill_stim(16'h0000);
    stim[0][1] = 16'h1234;
    stim[2][1] = 16'h4444;
    run_span(2, 0, 0, 7, 7);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        vectors++;
        if (capt[1][y][x] !== ramp_pix(y / 2, x / 2)) begin
          miscompares++;
          $display("FAIL ramp (%0d,%0d) got %h expected %h",
                   y, x, capt[1][y][x], ramp_pix(y / 2, x / 2));
        end
      end
  endtask

  // Frame 3 skips coarse column 1 of rows 0 and 2: both blocks replay the
  // last value stored in that bank entry (0x4444 from frame 2, row 2).
  task automatic test_stale();
    logic [15:0] want;
    fill_stim(16'h5566);
    stim_en[0][1] = 1'b0;
    stim_en[2][1] = 1'b0;
    run_span(3, 0, 0, 7, 7);
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 6; x++) begin
        want = ((y < 2 || y >= 4) && (x == 2 || x == 3)) ? 16'h4444 : 16'h5566;
        vectors++;
        if (capt[1][y][x] !== want) begin
          miscompares++;
          $display("FAIL stale (%0d,%0d) got %h expected %h", y, x, capt[1][y][x], want);
        end
      end
    vectors++;
    if (capt[0][0][2] !== 16'h1234) begin
      miscompares++; $display("FAIL prior_row0 got %h expected 1234", capt[0][0][2]);
    end
    vectors++;
    if (capt[0][4][3] !== 16'h4444) begin
      miscompares++; $display("FAIL prior_row2 got %h expected 4444", capt[0][4][3]);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        stim[r][c]    = ramp_pix(r, c);
        stim_en[r][c] = 1'b1;
      end
    run_span(4, 0, 0, 4, 3);
    #2 n_rst = 1'b0;
    #1;
    vectors++;
    if (out_pixels !== 16'h0000 || out_vcnt !== 3'd0 || out_hcnt !== 3'd0) begin
      miscompares++;
      $display("FAIL async_clear got pix=%h v=%0d h=%0d expected 0000 0 0",
               out_pixels, out_vcnt, out_hcnt);
    end
    hok[0] = 1'b0;
    hok[1] = 1'b0;
    #5 n_rst = 1'b1;
    k = 0;
    for (int idx = 4 * 8 + 4; idx < 64; idx++) begin
      cycle(idx / 8, idx % 8, 4, drive_en(idx / 8, idx % 8),
            drive_pix(idx / 8, idx % 8));
      if (k < 2) begin
        vectors++;
        if (obs_pix !== 16'h0000 || obs_v !== 0 || obs_h !== 0) begin
          miscompares++;
          $display("FAIL reset_refill got pix=%h v=%0d h=%0d expected 0000 0 0",
                   obs_pix, obs_v, obs_h);
        end
      end
      if (k == 2) begin
        vectors++;
        if (obs_v !== 2 || obs_h !== 4) begin
          miscompares++;
          $display("FAIL reset_track got v=%0d h=%0d expected v=2 h=4", obs_v, obs_h);
        end
      end
      k++;
    end
    fill_stim(16'h0000);
    run_span(5, 0, 0, 2, 1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        logic [15:0] want;
        if (y == 2 && (x == 2 || x == 3)) continue;
        if ((y == 2 && x >= 4) || y == 3) want = 16'h0000;
        else want = ramp_pix(y / 2, x / 2);
        vectors++;
        if (capt[0][y][x] !== want) begin
          miscompares++;
          $display("FAIL after_reset (%0d,%0d) got %h expected %h",
                   y, x, capt[0][y][x], want);
        end
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    hv = '{0, 0};
    hh = '{0, 0};
    hf = '{0, 0};
    hok = '{1'b0, 1'b0};
    test_reset();
    test_fill_after_reset();
    test_single_blocks();
    test_ramp();
    test_stale();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
